// File: rtl/quad_enc_gen.sv
// quad_enc_gen: quadrature encoder waveform generator (clk_fast domain).
// Emits A/B edges every programmed number of clk_fast cycles in the programmed
// direction. It also keeps a signed count of the edges it has emitted.
//
// Ports:
//   clk_fast    generator clock; every output is registered on it
//   reset       asynchronous, active-low
//   run         1 = timer counts, 0 = timer and A/B freeze
//   cmd_valid   command valid; hold it until it is accepted
//   cmd_ready   high while the shadow register is empty
//   cmd_period  clk_fast cycles between edges (0 = stop, clamped up to MIN_PERIOD)
//   cmd_dir     0 = forward (A leads), 1 = reverse (B leads)
//   pos_clr     synchronous clear of pos; it wins over a coincident edge
//   a, b        quadrature channels
//   dir_out     direction currently in effect
//   edge_o      one-cycle pulse in the cycle A or B changes
//   pos         signed two's-complement edge count; it wraps
//   idx         index pulse. It is built only when QUAD_GEN_INDEX_EN is defined,
//               and is tied to 0 otherwise.
//
// Optional feature macro: QUAD_GEN_INDEX_EN
module quad_enc_gen #(
  parameter int unsigned MIN_PERIOD = 2,
  parameter int unsigned CPR        = 4000
) (
  input  logic        clk_fast,
  input  logic        reset,
  input  logic        run,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [21:0] cmd_period,
  input  logic        cmd_dir,
  input  logic        pos_clr,
  output logic        a,
  output logic        b,
  output logic        dir_out,
  output logic        edge_o,
  output logic [31:0] pos,
  output logic        idx
);

  localparam logic [21:0] MIN_P = 22'(MIN_PERIOD);

  logic [21:0] period_q, period_d;
  logic [21:0] timer_q, timer_d;
  logic [21:0] sh_period_q, sh_period_d;
  logic        sh_dir_q, sh_dir_d;
  logic        sh_full_q, sh_full_d;
  logic        a_q, a_d, b_q, b_d;
  logic        dir_q, dir_d;
  logic        edge_q, edge_d;
  logic [31:0] pos_q, pos_d;
  logic [21:0] cmd_clamped;

  // A zero CPR is meaningless for the index; this guard block is intentionally empty.
  if (CPR == 0) begin : g_cpr_zero
  end

  always_comb begin
    cmd_clamped = cmd_period;
    if ((cmd_period != '0) && (cmd_period < MIN_P)) cmd_clamped = MIN_P;
  end

  always_comb begin
    period_d    = period_q;
    timer_d     = timer_q;
    sh_period_d = sh_period_q;
    sh_dir_d    = sh_dir_q;
    sh_full_d   = sh_full_q;
    a_d         = a_q;
    b_d         = b_q;
    dir_d       = dir_q;
    edge_d      = 1'b0;
    pos_d       = pos_q;

    // Accept only when the shadow is empty. Consumption below only happens
    // when it is full, so the two never collide in the same cycle.
    if (cmd_valid && !sh_full_q) begin
      sh_period_d = cmd_clamped;
      sh_dir_d    = cmd_dir;
      sh_full_d   = 1'b1;
    end

    if (period_q == '0) begin
      // Idle: apply a pending command right away, even while run=0.
      if (sh_full_q) begin
        period_d  = sh_period_q;
        timer_d   = sh_period_q;
        dir_d     = sh_dir_q;
        sh_full_d = 1'b0;
      end
    end else if (run) begin
      if (timer_q <= 22'd1) begin
        // This edge uses the old direction. A pending command then takes
        // over the following interval, and a period of 0 stops the generator.
        edge_d = 1'b1;
        if (!dir_q) begin
          a_d   = ~b_q;
          b_d   = a_q;
          pos_d = pos_q + 32'd1;
        end else begin
          a_d   = b_q;
          b_d   = ~a_q;
          pos_d = pos_q - 32'd1;
        end
        timer_d = period_q;
        if (sh_full_q) begin
          period_d  = sh_period_q;
          timer_d   = sh_period_q;
          dir_d     = sh_dir_q;
          sh_full_d = 1'b0;
        end
      end else begin
        timer_d = timer_q - 22'd1;
      end
    end

    if (pos_clr) pos_d = '0;
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      period_q    <= '0;
      timer_q     <= '0;
      sh_period_q <= '0;
      sh_dir_q    <= 1'b0;
      sh_full_q   <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      dir_q       <= 1'b0;
      edge_q      <= 1'b0;
      pos_q       <= '0;
    end else begin
      period_q    <= period_d;
      timer_q     <= timer_d;
      sh_period_q <= sh_period_d;
      sh_dir_q    <= sh_dir_d;
      sh_full_q   <= sh_full_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dir_q       <= dir_d;
      edge_q      <= edge_d;
      pos_q       <= pos_d;
    end
  end

`ifdef QUAD_GEN_INDEX_EN
  localparam logic signed [31:0] CPR_S = 32'(CPR);
  logic idx_q, idx_d;

  // idx is computed from next-state values so it lines up with a/b.
  // Testing the remainder for zero is sign-independent, so negative pos matches too.
  always_comb begin
    idx_d = 1'b0;
    if (!a_d && !b_d && (($signed(pos_d) % CPR_S) == 32'sd0)) idx_d = 1'b1;
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) idx_q <= 1'b0;
    else        idx_q <= idx_d;
  end

  assign idx = idx_q;
`else
  assign idx = 1'b0;
`endif

  assign cmd_ready = ~sh_full_q;
  assign a         = a_q;
  assign b         = b_q;
  assign dir_out   = dir_q;
  assign edge_o    = edge_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
module tb_quad_enc_gen;

`ifdef QUAD_GEN_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic        clk_fast = 1'b0;
  logic        reset;
  logic        run;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [21:0] cmd_period;
  logic        cmd_dir;
  logic        pos_clr;
  logic        a, b, dir_out, edge_o, idx;
  logic [31:0] pos;

  int checks = 0;
  int errors = 0;

  quad_enc_gen #(.MIN_PERIOD(2), .CPR(8)) dut (
    .clk_fast(clk_fast), .reset(reset), .run(run), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_period(cmd_period), .cmd_dir(cmd_dir),
    .pos_clr(pos_clr), .a(a), .b(b), .dir_out(dir_out), .edge_o(edge_o),
    .pos(pos), .idx(idx)
  );

  initial forever #5 clk_fast = ~clk_fast;

  // Bounded wait for the next edge_o pulse, sampled on negedges.
  task automatic wait_edge(input int max, output int cnt, output bit found);
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < max) begin
      @(negedge clk_fast);
      cnt++;
      if (edge_o) found = 1'b1;
    end
  endtask

  task automatic send_cmd(input logic [21:0] p, input logic d);
    cmd_period = p;
    cmd_dir = d;
    cmd_valid = 1'b1;
    @(negedge clk_fast);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b0; cmd_valid = 1'b0; cmd_period = '0; cmd_dir = 1'b0; pos_clr = 1'b0;
    repeat (3) @(negedge clk_fast);
    checks++; if ({a, b, dir_out, edge_o, idx} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b want 00000", {a, b, dir_out, edge_o, idx}); end
    checks++; if (pos !== 32'd0) begin errors++; $display("FAIL reset_pos got %h want 0", pos); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    reset = 1'b1;
    @(negedge clk_fast);
  endtask

  task automatic test_first_edge;
    int cnt; bit found;
    logic [1:0] exp_ab [3] = '{2'b11, 2'b01, 2'b00};
    run = 1'b1;
    send_cmd(22'd10, 1'b0);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_after_accept got %b want 0", cmd_ready); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 11) begin errors++; $display("FAIL first_edge_latency got %0d (found %0d) want 11", cnt, found); end
    checks++; if ({a, b} !== 2'b10 || pos !== 32'd1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL first_edge_state ab=%b pos=%0d rdy=%b want 10 1 1", {a, b}, pos, cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      wait_edge(20, cnt, found);
      checks++; if (!found || cnt != 10) begin errors++; $display("FAIL fwd_interval[%0d] got %0d want 10", i, cnt); end
      checks++; if ({a, b} !== exp_ab[i] || pos !== 32'(i + 2)) begin errors++; $display("FAIL fwd_state[%0d] ab=%b pos=%0d want %b %0d", i, {a, b}, pos, exp_ab[i], i + 2); end
    end
  endtask

  task automatic test_reverse;
    int cnt; bit found;
    send_cmd(22'd3, 1'b1);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rev_ready_low got %b want 0", cmd_ready); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 9 || {a, b} !== 2'b10 || pos !== 32'd5) begin errors++; $display("FAIL rev_switch_edge cnt=%0d ab=%b pos=%0d want 9 10 5", cnt, {a, b}, pos); end
    checks++; if (dir_out !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rev_applied dir=%b rdy=%b want 1 1", dir_out, cmd_ready); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 3 || {a, b} !== 2'b00 || pos !== 32'd4) begin errors++; $display("FAIL rev_edge1 cnt=%0d ab=%b pos=%0d want 3 00 4", cnt, {a, b}, pos); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 3 || {a, b} !== 2'b01 || pos !== 32'd3) begin errors++; $display("FAIL rev_edge2 cnt=%0d ab=%b pos=%0d want 3 01 3", cnt, {a, b}, pos); end
  endtask

  task automatic test_clamp_and_stop;
    int cnt; bit found;
    send_cmd(22'd1, 1'b0);
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 2 || {a, b} !== 2'b11 || pos !== 32'd2 || dir_out !== 1'b0) begin errors++; $display("FAIL clamp_switch cnt=%0d ab=%b pos=%0d dir=%b want 2 11 2 0", cnt, {a, b}, pos, dir_out); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 2 || {a, b} !== 2'b01 || pos !== 32'd3) begin errors++; $display("FAIL clamp_edge1 cnt=%0d ab=%b pos=%0d want 2 01 3", cnt, {a, b}, pos); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 2 || {a, b} !== 2'b00 || pos !== 32'd4) begin errors++; $display("FAIL clamp_edge2 cnt=%0d ab=%b pos=%0d want 2 00 4", cnt, {a, b}, pos); end
    send_cmd(22'd0, 1'b0);
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 1 || {a, b} !== 2'b10 || pos !== 32'd5) begin errors++; $display("FAIL stop_last_edge cnt=%0d ab=%b pos=%0d want 1 10 5", cnt, {a, b}, pos); end
    wait_edge(30, cnt, found);
    checks++; if (found || {a, b} !== 2'b10 || pos !== 32'd5) begin errors++; $display("FAIL stop_hold found=%0d ab=%b pos=%0d want 0 10 5", found, {a, b}, pos); end
  endtask

  task automatic test_pause;
    int cnt; bit found;
    send_cmd(22'd10, 1'b0);
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 11 || {a, b} !== 2'b11 || pos !== 32'd6) begin errors++; $display("FAIL restart_edge cnt=%0d ab=%b pos=%0d want 11 11 6", cnt, {a, b}, pos); end
    repeat (6) @(negedge clk_fast);
    run = 1'b0;
    wait_edge(50, cnt, found);
    checks++; if (found || {a, b} !== 2'b11) begin errors++; $display("FAIL pause_no_edge found=%0d ab=%b want 0 11", found, {a, b}); end
    run = 1'b1;
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 4 || {a, b} !== 2'b01 || pos !== 32'd7) begin errors++; $display("FAIL resume_edge cnt=%0d ab=%b pos=%0d want 4 01 7", cnt, {a, b}, pos); end
  endtask

  task automatic test_pos_clr;
    repeat (9) @(negedge clk_fast);
    pos_clr = 1'b1;
    @(negedge clk_fast);
    pos_clr = 1'b0;
    checks++; if (edge_o !== 1'b1 || {a, b} !== 2'b00 || pos !== 32'd0) begin errors++; $display("FAIL clr_vs_edge edge=%b ab=%b pos=%0d want 1 00 0", edge_o, {a, b}, pos); end
  endtask

  task automatic test_wrap;
    int cnt; bit found;
    force dut.pos_q = 32'h7FFF_FFFF;
    @(negedge clk_fast);
    release dut.pos_q;
    checks++; if (pos !== 32'h7FFF_FFFF) begin errors++; $display("FAIL preload got %h want 7fffffff", pos); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 9 || pos !== 32'h8000_0000 || {a, b} !== 2'b10) begin errors++; $display("FAIL wrap_up cnt=%0d pos=%h ab=%b want 9 80000000 10", cnt, pos, {a, b}); end
    send_cmd(22'd10, 1'b1);
    wait_edge(20, cnt, found);
    checks++; if (!found || pos !== 32'h8000_0001 || {a, b} !== 2'b11) begin errors++; $display("FAIL wrap_last_fwd pos=%h ab=%b want 80000001 11", pos, {a, b}); end
    wait_edge(20, cnt, found);
    checks++; if (!found || cnt != 10 || pos !== 32'h8000_0000 || {a, b} !== 2'b10) begin errors++; $display("FAIL undo_edge cnt=%0d pos=%h ab=%b want 10 80000000 10", cnt, pos, {a, b}); end
    wait_edge(20, cnt, found);
    checks++; if (!found || pos !== 32'h7FFF_FFFF || {a, b} !== 2'b00) begin errors++; $display("FAIL wrap_down pos=%h ab=%b want 7fffffff 00", pos, {a, b}); end
  endtask

  task automatic test_index;
    int cnt; bit found;
    reset = 1'b0;
    @(negedge clk_fast);
    reset = 1'b1;
    send_cmd(22'd2, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) send_cmd(22'd2, 1'b1);
      wait_edge(10, cnt, found);
      if (i == 4) begin
        checks++; if (!found || {a, b} !== 2'b00 || pos !== 32'd4 || idx !== 1'b0) begin errors++; $display("FAIL idx_pos4 ab=%b pos=%0d idx=%b want 00 4 0", {a, b}, pos, idx); end
      end
    end
    checks++; if (!found || {a, b} !== 2'b00 || pos !== 32'd8 || idx !== IDX_EN) begin errors++; $display("FAIL idx_pos8 ab=%b pos=%0d idx=%b want 00 8 %b", {a, b}, pos, idx, IDX_EN); end
    for (int i = 1; i <= 16; i++) begin
      wait_edge(10, cnt, found);
      if (i == 1) begin
        checks++; if (!found || {a, b} !== 2'b01 || idx !== 1'b0) begin errors++; $display("FAIL idx_off ab=%b idx=%b want 01 0", {a, b}, idx); end
      end
      if (i == 8) begin
        checks++; if (!found || {a, b} !== 2'b00 || pos !== 32'd0 || idx !== IDX_EN) begin errors++; $display("FAIL idx_pos0 ab=%b pos=%0d idx=%b want 00 0 %b", {a, b}, pos, idx, IDX_EN); end
      end
    end
    checks++; if (!found || {a, b} !== 2'b00 || pos !== 32'hFFFF_FFF8 || idx !== IDX_EN) begin errors++; $display("FAIL idx_neg8 ab=%b pos=%h idx=%b want 00 fffffff8 %b", {a, b}, pos, idx, IDX_EN); end
  endtask

  task automatic test_reset_mid;
    int cnt; bit found;
    wait_edge(10, cnt, found);
    checks++; if (!found || {a, b} !== 2'b01 || pos !== 32'hFFFF_FFF7) begin errors++; $display("FAIL pre_reset ab=%b pos=%h want 01 fffffff7", {a, b}, pos); end
    #3 reset = 1'b0;
    #1;
    checks++; if ({a, b, dir_out, edge_o, idx} !== 5'b0 || pos !== 32'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL async_reset outs=%b pos=%h rdy=%b want 00000 0 1", {a, b, dir_out, edge_o, idx}, pos, cmd_ready); end
    @(negedge clk_fast);
    reset = 1'b1;
    wait_edge(40, cnt, found);
    checks++; if (found || {a, b} !== 2'b00 || pos !== 32'd0) begin errors++; $display("FAIL post_reset_idle found=%0d ab=%b pos=%h want 0 00 0", found, {a, b}, pos); end
  endtask

  initial begin
    test_reset;
    test_first_edge;
    test_reverse;
    test_clamp_and_stop;
    test_pause;
    test_pos_clr;
    test_wrap;
    test_index;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
